fetch_decode_queue: RTL and testbench

- Small FIFO between the fetch stage and the decode stage of the pipelined core; replaces a bare IF/D register.
- Buffers fetched instructions together with their PC and PC+4. Back-pressures fetch through its enable, and presents a NOP bubble to decode when empty.
- Discards all buffered entries when a taken branch or jump resolves in Execute (flush).

---
 rtl/fetch_decode_queue.sv | 107 ++++++++++
 tb/tb_fetch_decode_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: buffers instr/PC/PC+4, shows a NOP bubble when empty, flushes on redirect.
// Optional macro FDQ_PERF_CNT_EN adds saturating stall_cycles and flush_drops counters.
module fetch_decode_queue #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 2,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(32'h00000013)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enq_valid,
   input  logic [DATA_WIDTH-1:0]   instrF,
   input  logic [DATA_WIDTH-1:0]   PCF,
   input  logic [DATA_WIDTH-1:0]   PCPlus4F,
   output logic                    enq_ready,
   input  logic                    deq_ready,
   input  logic                    flush,
   output logic                    validD,
   output logic [DATA_WIDTH-1:0]   instrD,
   output logic [DATA_WIDTH-1:0]   PCD,
   output logic [DATA_WIDTH-1:0]   PCPlus4D,
   output logic [$clog2(DEPTH):0]  count
`ifdef FDQ_PERF_CNT_EN
   ,
   output logic [31:0]             stall_cycles,
   output logic [31:0]             flush_drops
`endif
);

   localparam int            PW   = $clog2(DEPTH);
   localparam int            CW   = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] instr_q [DEPTH];
   logic [DATA_WIDTH-1:0] pc_q    [DEPTH];
   logic [DATA_WIDTH-1:0] pc4_q   [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic                  enq;
   logic                  deq;

   // Ready depends only on registered occupancy, so decode stalls never reach fetch combinationally.
   assign enq_ready = (count != FULL);
   assign validD    = (count != '0);
   assign enq       = enq_valid && enq_ready && !flush;
   assign deq       = deq_ready && validD && !flush;

   always_ff @(posedge clk) begin
      if (enq) begin
         instr_q[wr_ptr] <= instrF;
         pc_q[wr_ptr]    <= PCF;
         pc4_q[wr_ptr]   <= PCPlus4F;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (deq) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({enq, deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      instrD   = NOP_INSTR;
      PCD      = '0;
      PCPlus4D = '0;
      if (validD) begin
         instrD   = instr_q[rd_ptr];
         PCD      = pc_q[rd_ptr];
         PCPlus4D = pc4_q[rd_ptr];
      end
   end

`ifdef FDQ_PERF_CNT_EN
   logic [32:0] drop_sum;

   // Entries lost on a flush: everything buffered plus whatever fetch offered that cycle.
   assign drop_sum = {1'b0, flush_drops} + 33'(count) + 33'(enq_valid);

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_drops  <= '0;
      end else begin
         if (enq_valid && !enq_ready && !flush && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (flush) begin
            flush_drops <= drop_sum[32] ? '1 : drop_sum[31:0];
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomized bench for fetch_decode_queue against a queue-based reference model, plus directed literal checks.
module tb_fetch_decode_queue;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        clk = 1'b0;
   logic        reset, enq_valid, deq_ready, flush;
   logic [31:0] instrF, PCF, PCPlus4F;
   logic        enq_ready, validD;
   logic [31:0] instrD, PCD, PCPlus4D;
   logic [1:0]  count;
`ifdef FDQ_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_drops;
   longint      stallModel, dropModel;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc4;
   } entry_t;

   entry_t mq[$];
   bit     lastAcc;
   int     checks = 0;
   int     errors = 0;

   fetch_decode_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk(clk), .reset(reset), .enq_valid(enq_valid), .instrF(instrF), .PCF(PCF),
      .PCPlus4F(PCPlus4F), .enq_ready(enq_ready), .deq_ready(deq_ready), .flush(flush),
      .validD(validD), .instrD(instrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .count(count)
`ifdef FDQ_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .flush_drops(flush_drops)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a plain FIFO of entries; flush/reset empty it, full blocks new entries.
   task automatic modelUpdate();
      bit canEnq, canDeq;
      canEnq  = enq_valid && (mq.size() != DEPTH) && !flush;
      canDeq  = deq_ready && (mq.size() != 0) && !flush;
      lastAcc = canEnq && !reset;
`ifdef FDQ_PERF_CNT_EN
      if (reset) begin
         stallModel = 0;
         dropModel  = 0;
      end else begin
         if (enq_valid && mq.size() == DEPTH && !flush) stallModel++;
         if (flush) dropModel += mq.size() + (enq_valid ? 1 : 0);
         if (stallModel > 64'hFFFFFFFF) stallModel = 64'hFFFFFFFF;
         if (dropModel > 64'hFFFFFFFF) dropModel = 64'hFFFFFFFF;
      end
`endif
      if (reset || flush) begin
         mq.delete();
      end else begin
         if (canDeq) void'(mq.pop_front());
         if (canEnq) mq.push_back('{instrF, PCF, PCPlus4F});
      end
   endtask

   task automatic checkOutput();
      bit emp;
      emp = (mq.size() == 0);
      checkVal("validD", validD, !emp);
      checkVal("instrD", instrD, emp ? NOP : mq[0].instr);
      checkVal("PCD", PCD, emp ? 32'd0 : mq[0].pc);
      checkVal("PCPlus4D", PCPlus4D, emp ? 32'd0 : mq[0].pc4);
      checkVal("count", count, mq.size());
      checkVal("enq_ready", enq_ready, mq.size() != DEPTH);
`ifdef FDQ_PERF_CNT_EN
      checkVal("stall_cycles", stall_cycles, stallModel);
      checkVal("flush_drops", flush_drops, dropModel);
`endif
   endtask

   // Inputs change at the falling edge; model steps at the rising edge; outputs checked at the next falling edge.
   task automatic applyStimulus(input logic rst, input logic ev, input logic [31:0] ins,
                                input logic [31:0] pc, input logic dr, input logic fl);
      reset     = rst;
      enq_valid = ev;
      instrF    = ins;
      PCF       = pc;
      PCPlus4F  = pc + 32'd4;
      deq_ready = dr;
      flush     = fl;
      @(posedge clk);
      modelUpdate();
      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      logic [31:0] fpc, hInstr;
      bit          holding;
      logic        rst, fl, ev, dr;

`ifdef FDQ_PERF_CNT_EN
      stallModel = 0;
      dropModel  = 0;
`endif
      reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
      instrF = '0; PCF = '0; PCPlus4F = '0;

      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkVal("lit_reset_valid", validD, 0);
      checkVal("lit_reset_instr", instrD, 32'h00000013);
      checkVal("lit_reset_pc", PCD, 0);
      checkVal("lit_reset_ready", enq_ready, 1);
      checkVal("lit_reset_count", count, 0);

      applyStimulus(0, 1, 32'h00500093, 32'h0, 0, 0);
      checkVal("lit_enq_valid", validD, 1);
      checkVal("lit_enq_instr", instrD, 32'h00500093);
      checkVal("lit_enq_pc4", PCPlus4D, 32'h4);
      checkVal("lit_enq_count", count, 1);

      applyStimulus(0, 1, 32'h00100113, 32'h4, 0, 0);
      checkVal("lit_full_ready", enq_ready, 0);
      checkVal("lit_full_count", count, 2);
      applyStimulus(0, 1, 32'h00200193, 32'h8, 0, 0);
      checkVal("lit_held_count", count, 2);
      checkVal("lit_held_pc", PCD, 32'h0);
      applyStimulus(0, 1, 32'h00200193, 32'h8, 1, 0);
      checkVal("lit_drain_pc1", PCD, 32'h4);
      applyStimulus(0, 1, 32'h00200193, 32'h8, 1, 0);
      checkVal("lit_drain_pc2", PCD, 32'h8);
      checkVal("lit_drain_count2", count, 1);
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkVal("lit_drain_empty", validD, 0);

      for (int i = 0; i <= 8; i++) begin
         applyStimulus(0, 1, 32'h00000093 + i, 32'(i * 4), 1, 0);
         checkVal("lit_stream_pc", PCD, 32'(i * 4));
         checkVal("lit_stream_count", count, 1);
      end
      applyStimulus(0, 0, 0, 0, 1, 0);

      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 32'h11, 32'h0, 0, 0);
      applyStimulus(0, 1, 32'h22, 32'h4, 0, 0);
      applyStimulus(0, 1, 32'h33, 32'h8, 1, 1);
      checkVal("lit_flush_count", count, 0);
      checkVal("lit_flush_valid", validD, 0);
      checkVal("lit_flush_instr", instrD, 32'h00000013);
`ifdef FDQ_PERF_CNT_EN
      checkVal("lit_flush_drops", flush_drops, 3);
`endif
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkVal("lit_flush_noghost", validD, 0);

      applyStimulus(0, 1, 32'h44, 32'h0, 0, 0);
      applyStimulus(0, 1, 32'h55, 32'h4, 0, 0);
      applyStimulus(0, 1, 32'h66, 32'h8, 0, 0);
      applyStimulus(1, 1, 32'h66, 32'h8, 0, 0);
      checkVal("lit_rst_count", count, 0);
      checkVal("lit_rst_ready", enq_ready, 1);
      checkVal("lit_rst_valid", validD, 0);
`ifdef FDQ_PERF_CNT_EN
      checkVal("lit_rst_stall", stall_cycles, 0);
`endif

      // Random traffic: fetch holds an un-accepted instruction and is redirected on flush/reset.
      fpc     = 32'h0;
      hInstr  = $urandom;
      holding = 0;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         fl  = !rst && ($urandom_range(0, 11) == 0);
         if (holding) begin
            ev = 1'b1;
         end else begin
            ev     = ($urandom_range(0, 3) != 0);
            hInstr = $urandom;
         end
         dr = ($urandom_range(0, 99) < (((i / 500) % 2) != 0 ? 30 : 80));
         applyStimulus(rst, ev, hInstr, fpc, dr, fl);
         if (rst || fl) begin
            holding = 0;
            fpc     = rst ? 32'h0 : ($urandom & 32'hFFFF_FFFC);
         end else if (ev && lastAcc) begin
            holding = 0;
            fpc     = fpc + 32'd4;
         end else if (ev) begin
            holding = 1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
